// File: rtl/adder_display_pkg.sv
// Shared types and constants for the adder_scan_display block.
// Holds the controller state encoding, the active-low seven-segment glyphs
// ({g,f,e,d,c,b,a}), and small elaboration-time helpers for sizing.
package adder_display_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        UPDATE = 2'd2
    } state_e;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;

    // Width of the packed BCD register for a given digit count.
    function automatic int unsigned bcd_width(input int unsigned digits);
        return 4 * digits;
    endfunction

    // 10**n as a 64-bit value; used for the overflow threshold.
    function automatic logic [63:0] pow10(input int unsigned n);
        logic [63:0] r;
        r = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/adder_scan_display_if.sv
// Operand/display bundle for adder_scan_display.
//   A, B, CI, load : operands and capture strobe (driven by master)
//   seg            : active-low segments {g..a}
//   an             : active-low anode enables, an[0] = least-significant digit
//   busy           : conversion in progress
//   overflow       : last captured sum does not fit in DIGITS decimal digits
interface adder_scan_display_if #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned DIGITS = 4
);
    logic [WIDTH-1:0]  A;
    logic [WIDTH-1:0]  B;
    logic              CI;
    logic              load;
    logic [6:0]        seg;
    logic [DIGITS-1:0] an;
    logic              busy;
    logic              overflow;

    modport master (
        output A, B, CI, load,
        input  seg, an, busy, overflow
    );

    modport slave (
        input  A, B, CI, load,
        output seg, an, busy, overflow
    );
endinterface

// File: rtl/seg7_decode.sv
// BCD nibble to active-low seven-segment pattern {g,f,e,d,c,b,a}.
//   bcd_i : BCD digit 0..9
//   seg_o : segment pattern; codes above 9 decode to blank
module seg7_decode
    import adder_display_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/adder_scan_display.sv
// Registers A+B+CI on a load strobe, converts the sum to BCD with a
// sequential double-dabble, and scans the result onto a multiplexed
// common-anode seven-segment display.
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   bus  : slave side of adder_scan_display_if (operands, load, seg/an,
//          busy, overflow)
module adder_scan_display
    import adder_display_pkg::*;
#(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned REFRESH_DIV = 100000,
    parameter bit          LZ_BLANK    = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    adder_scan_display_if.slave  bus
);

    localparam int unsigned SumW = WIDTH + 1;
    localparam int unsigned BcdW = bcd_width(DIGITS);
    localparam int unsigned ShW  = BcdW + SumW;
    localparam int unsigned CntW = $clog2(SumW + 1);
    localparam int unsigned RefW = $clog2(REFRESH_DIV);
    localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [63:0] OvfLimit = pow10(DIGITS);

    // Controller / converter state
    state_e            state_q, state_d;
    logic [ShW-1:0]    shift_q, shift_d;
    logic [CntW-1:0]   step_q, step_d;
    logic              ovf_pend_q, ovf_pend_d;
    logic              ovf_q, ovf_d;
    logic [BcdW-1:0]   disp_q, disp_d;
    logic              valid_q, valid_d;

    // Scanner state
    logic [RefW-1:0]   ref_q, ref_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [6:0]        seg_q, seg_d;
    logic [DIGITS-1:0] an_q, an_d;

    logic [SumW-1:0]   sum;
    logic [ShW-1:0]    dd_next;
    logic [3:0]        cur_nib;
    logic [6:0]        dec_seg;
    logic [IdxW-1:0]   msd;

    assign sum = SumW'(bus.A) + SumW'(bus.B) + SumW'(bus.CI);

    // One double-dabble step: correct every BCD nibble >= 5, then shift.
    always_comb begin
        logic [ShW-1:0] adj;
        adj = shift_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (shift_q[SumW + 4*i +: 4] >= 4'd5) begin
                adj[SumW + 4*i +: 4] = shift_q[SumW + 4*i +: 4] + 4'd3;
            end
        end
        dd_next = adj << 1;
    end

    // Capture / convert / publish controller.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        step_d     = step_q;
        ovf_pend_d = ovf_pend_q;
        ovf_d      = ovf_q;
        disp_d     = disp_q;
        valid_d    = valid_q;
        unique case (state_q)
            IDLE: begin
                if (bus.load) begin
                    shift_d    = {{BcdW{1'b0}}, sum};
                    ovf_pend_d = (64'(sum) >= OvfLimit);
                    step_d     = '0;
                    state_d    = CONV;
                end
            end
            CONV: begin
                shift_d = dd_next;
                step_d  = step_q + CntW'(1);
                if (step_q == CntW'(SumW - 1)) begin
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                disp_d  = shift_q[ShW-1 -: BcdW];
                valid_d = 1'b1;
                ovf_d   = ovf_pend_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Refresh counter and digit index.
    always_comb begin
        ref_d = ref_q + RefW'(1);
        idx_d = idx_q;
        if (ref_q == RefW'(REFRESH_DIV - 1)) begin
            ref_d = '0;
            idx_d = (idx_q == IdxW'(DIGITS - 1)) ? '0 : idx_q + IdxW'(1);
        end
    end

    // Nibble under the current index, and the most-significant nonzero digit
    // (stays 0 for an all-zero value so digit 0 always shows).
    always_comb begin
        cur_nib = '0;
        msd     = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (idx_q == IdxW'(i)) begin
                cur_nib = disp_q[4*i +: 4];
            end
            if (disp_q[4*i +: 4] != 4'd0) begin
                msd = IdxW'(i);
            end
        end
    end

    seg7_decode u_seg7_decode (
        .bcd_i (cur_nib),
        .seg_o (dec_seg)
    );

    // seg and an are registered together from the same index so they never skew.
    always_comb begin
        if (!valid_q) begin
            seg_d = SEG_BLANK;
        end else if (ovf_q) begin
            seg_d = SEG_DASH;
        end else if (LZ_BLANK && (idx_q > msd)) begin
            seg_d = SEG_BLANK;
        end else begin
            seg_d = dec_seg;
        end
        an_d = ~(DIGITS'(1) << idx_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            step_q     <= '0;
            ovf_pend_q <= 1'b0;
            ovf_q      <= 1'b0;
            disp_q     <= '0;
            valid_q    <= 1'b0;
            ref_q      <= '0;
            idx_q      <= '0;
            seg_q      <= SEG_BLANK;
            an_q       <= '1;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            step_q     <= step_d;
            ovf_pend_q <= ovf_pend_d;
            ovf_q      <= ovf_d;
            disp_q     <= disp_d;
            valid_q    <= valid_d;
            ref_q      <= ref_d;
            idx_q      <= idx_d;
            seg_q      <= seg_d;
            an_q       <= an_d;
        end
    end

    assign bus.seg      = seg_q;
    assign bus.an       = an_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_adder_scan_display.sv
// Bench for adder_scan_display: three instances (4 digits with and without
// leading-zero blanking, and a single digit) share clock, reset and operands.
module tb_adder_scan_display;

    localparam int unsigned RDIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] a_drv = '0;
    logic [3:0] b_drv = '0;
    logic       ci_drv = 1'b0;
    logic       load_drv = 1'b0;

    always #5 clk = ~clk;

    adder_scan_display_if #(.WIDTH(4), .DIGITS(4)) bus_a ();
    adder_scan_display_if #(.WIDTH(4), .DIGITS(4)) bus_b ();
    adder_scan_display_if #(.WIDTH(4), .DIGITS(1)) bus_c ();

    assign bus_a.A = a_drv;  assign bus_a.B = b_drv;
    assign bus_a.CI = ci_drv; assign bus_a.load = load_drv;
    assign bus_b.A = a_drv;  assign bus_b.B = b_drv;
    assign bus_b.CI = ci_drv; assign bus_b.load = load_drv;
    assign bus_c.A = a_drv;  assign bus_c.B = b_drv;
    assign bus_c.CI = ci_drv; assign bus_c.load = load_drv;

    adder_scan_display #(.WIDTH(4), .DIGITS(4), .REFRESH_DIV(RDIV), .LZ_BLANK(1'b1)) dut_a (
        .clk (clk), .rst (rst), .bus (bus_a)
    );
    adder_scan_display #(.WIDTH(4), .DIGITS(4), .REFRESH_DIV(RDIV), .LZ_BLANK(1'b0)) dut_b (
        .clk (clk), .rst (rst), .bus (bus_b)
    );
    adder_scan_display #(.WIDTH(4), .DIGITS(1), .REFRESH_DIV(RDIV), .LZ_BLANK(1'b1)) dut_c (
        .clk (clk), .rst (rst), .bus (bus_c)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Observation mux over the three instances; unused anode bits read as 1.
    int         sel = 0;
    logic [7:0] an_obs;
    logic [6:0] seg_obs;
    logic       busy_obs;
    logic       ovf_obs;

    always_comb begin
        an_obs   = 8'hFF;
        seg_obs  = bus_a.seg;
        busy_obs = bus_a.busy;
        ovf_obs  = bus_a.overflow;
        case (sel)
            0: an_obs[3:0] = bus_a.an;
            1: begin
                an_obs[3:0] = bus_b.an;
                seg_obs     = bus_b.seg;
                busy_obs    = bus_b.busy;
                ovf_obs     = bus_b.overflow;
            end
            default: begin
                an_obs[0] = bus_c.an;
                seg_obs   = bus_c.seg;
                busy_obs  = bus_c.busy;
                ovf_obs   = bus_c.overflow;
            end
        endcase
    end

    function automatic int dig_of(input int s);
        return (s == 2) ? 1 : 4;
    endfunction

    function automatic bit lz_of(input int s);
        return (s != 1);
    endfunction

    function automatic int pow10(input int n);
        int r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [6:0] glyph(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Expected segments for one digit position of a display showing 'sum'.
    function automatic logic [6:0] model_seg(input int sum, input int idx, input int digits,
                                             input bit lz, input bit valid);
        if (!valid) return 7'b1111111;
        if (sum >= pow10(digits)) return 7'b0111111;
        if (lz && idx > 0 && sum < pow10(idx)) return 7'b1111111;
        return glyph((sum / pow10(idx)) % 10);
    endfunction

    // Scan capture results
    logic [6:0] seen_seg [8];
    int         seen_n   [8];
    int         bad_an;
    int         bad_run;
    int         bad_seg;

    // Watch two full scans of one instance: anode must be one-hot low, each
    // digit held RDIV cycles, index stepping +1 modulo DIGITS.
    task automatic capture_scan(input int s);
        int  digits, prev, run, idx;
        bit  first;
        logic [7:0] zeros;
        digits = dig_of(s);
        sel = s;
        for (int i = 0; i < 8; i++) begin
            seen_n[i]   = 0;
            seen_seg[i] = 7'h00;
        end
        bad_an = 0; bad_run = 0; bad_seg = 0;
        prev = -1; run = 0; first = 1'b1;
        repeat (2 * digits * RDIV + 2) begin
            @(negedge clk);
            zeros = ~an_obs;
            idx = 0;
            for (int i = 0; i < 8; i++) if (zeros[i] === 1'b1) idx = i;
            if (!$onehot(zeros) || idx >= digits) begin
                bad_an++;
            end else begin
                if (seen_n[idx] > 0 && seen_seg[idx] !== seg_obs) bad_seg++;
                seen_seg[idx] = seg_obs;
                seen_n[idx]++;
                if (prev < 0) begin
                    prev = idx; run = 1;
                end else if (idx == prev) begin
                    run++;
                end else begin
                    if (!first && run != int'(RDIV)) bad_run++;
                    if (idx != (prev + 1) % digits) bad_run++;
                    first = 1'b0;
                    prev = idx; run = 1;
                end
            end
        end
    endtask

    task automatic do_load(input int a, input int b, input int ci);
        @(negedge clk);
        a_drv = 4'(a); b_drv = 4'(b); ci_drv = 1'(ci);
        load_drv = 1'b1;
        @(negedge clk);
        load_drv = 1'b0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (bus_a.busy === 1'b1 && n < 50) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        int cyc;
        @(negedge clk);
        rst = 1'b0;
        cyc = $urandom_range(5, 13);
        repeat (cyc) @(negedge clk);
        #($urandom_range(1, 8));
        rst = 1'b1;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            n_cmp++;
            if ({seg_obs, an_obs, busy_obs, ovf_obs} !== {7'h7F, 8'hFF, 2'b00}) begin
                n_err++;
                $display("FAIL reset_outputs dut%0d: got seg=%b an=%b busy=%b ovf=%b want 1111111/11111111/0/0",
                         s, seg_obs, an_obs, busy_obs, ovf_obs);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            capture_scan(s);
            n_cmp++;
            if (bad_an + bad_run + bad_seg != 0) begin
                n_err++;
                $display("FAIL reset_scan dut%0d: got an/run/seg errors %0d/%0d/%0d want 0/0/0",
                         s, bad_an, bad_run, bad_seg);
            end
            for (int i = 0; i < dig_of(s); i++) begin
                n_cmp++;
                if (seen_n[i] == 0 || seen_seg[i] !== 7'b1111111) begin
                    n_err++;
                    $display("FAIL reset_blank dut%0d digit%0d: got %b (seen %0d) want 1111111",
                             s, i, seen_seg[i], seen_n[i]);
                end
            end
        end
    endtask

    task automatic test_add(input string name, input int a, input int b, input int ci);
        int n, sum;
        logic [6:0] exp;
        sum = a + b + ci;
        do_load(a, b, ci);
        count_busy(n);
        n_cmp++;
        if (n != 6) begin
            n_err++;
            $display("FAIL %s busy_cycles: got %0d want 6", name, n);
        end
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            capture_scan(s);
            n_cmp++;
            if (ovf_obs !== 1'(sum >= pow10(dig_of(s)))) begin
                n_err++;
                $display("FAIL %s overflow dut%0d: got %b want %0d", name, s, ovf_obs,
                         sum >= pow10(dig_of(s)));
            end
            n_cmp++;
            if (bad_an + bad_run + bad_seg != 0) begin
                n_err++;
                $display("FAIL %s scan dut%0d: got an/run/seg errors %0d/%0d/%0d want 0/0/0",
                         name, s, bad_an, bad_run, bad_seg);
            end
            for (int i = 0; i < dig_of(s); i++) begin
                exp = model_seg(sum, i, dig_of(s), lz_of(s), 1'b1);
                n_cmp++;
                if (seen_n[i] == 0 || seen_seg[i] !== exp) begin
                    n_err++;
                    $display("FAIL %s digit dut%0d idx%0d (sum %0d): got %b want %b",
                             name, s, i, sum, seen_seg[i], exp);
                end
            end
        end
    endtask

    task automatic test_busy_drop();
        int n1, n2, late;
        logic [6:0] exp;
        do_load(9, 2, 0);
        n1 = (bus_a.busy === 1'b1) ? 1 : 0;
        @(negedge clk);
        if (bus_a.busy === 1'b1) n1++;
        a_drv = 4'd1; b_drv = 4'd1; ci_drv = 1'b0;
        load_drv = 1'b1;
        @(negedge clk);
        load_drv = 1'b0;
        count_busy(n2);
        n_cmp++;
        if (n1 + n2 != 6) begin
            n_err++;
            $display("FAIL busy_drop busy_cycles: got %0d want 6", n1 + n2);
        end
        late = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus_a.busy !== 1'b0) late++;
        end
        n_cmp++;
        if (late != 0) begin
            n_err++;
            $display("FAIL busy_drop requeued: got %0d busy cycles want 0", late);
        end
        for (int s = 0; s < 3; s++) begin
            capture_scan(s);
            for (int i = 0; i < dig_of(s); i++) begin
                exp = model_seg(11, i, dig_of(s), lz_of(s), 1'b1);
                n_cmp++;
                if (seen_n[i] == 0 || seen_seg[i] !== exp) begin
                    n_err++;
                    $display("FAIL busy_drop digit dut%0d idx%0d: got %b want %b",
                             s, i, seen_seg[i], exp);
                end
            end
        end
    endtask

    task automatic test_reset_mid_conv();
        int late;
        do_load(8, 8, 0);
        repeat (2) @(negedge clk);
        n_cmp++;
        if (bus_a.busy !== 1'b1) begin
            n_err++;
            $display("FAIL midconv busy_before_reset: got %b want 1", bus_a.busy);
        end
        rst = 1'b1;
        #1;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            n_cmp++;
            if ({seg_obs, an_obs, busy_obs, ovf_obs} !== {7'h7F, 8'hFF, 2'b00}) begin
                n_err++;
                $display("FAIL midconv_outputs dut%0d: got seg=%b an=%b busy=%b ovf=%b want 1111111/11111111/0/0",
                         s, seg_obs, an_obs, busy_obs, ovf_obs);
            end
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        late = 0;
        repeat (20) begin
            @(negedge clk);
            if ({bus_a.busy, bus_b.busy, bus_c.busy} !== 3'b000) late++;
        end
        n_cmp++;
        if (late != 0) begin
            n_err++;
            $display("FAIL midconv resumed: got %0d busy cycles want 0", late);
        end
        for (int s = 0; s < 3; s++) begin
            capture_scan(s);
            for (int i = 0; i < dig_of(s); i++) begin
                n_cmp++;
                if (seen_n[i] == 0 || seen_seg[i] !== 7'b1111111) begin
                    n_err++;
                    $display("FAIL midconv_blank dut%0d idx%0d: got %b want 1111111",
                             s, i, seen_seg[i]);
                end
            end
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        test_add("sum_2_3", 2, 3, 0);
        test_add("sum_15_15_1", 15, 15, 1);
        test_busy_drop();
        test_add("ovf_9_2", 9, 2, 0);
        test_add("ovf_4_5", 4, 5, 0);
        test_add("zero", 0, 0, 0);
        for (int k = 0; k < 12; k++) begin
            test_add("random", int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                     int'($urandom_range(0, 1)));
        end
        test_reset_mid_conv();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
